// File: rtl/wb_bus_pkg.sv
// rtl/wb_bus_pkg.sv - shared widths, slave-select field and FSM encoding for the shared Wishbone bus
package wb_bus_pkg;

    localparam int WB_AW  = 32;
    localparam int WB_DW  = 32;
    localparam int WB_SW  = 4;
    localparam int SLV_HI = 31;
    localparam int SLV_LO = 28;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } bus_state_t;

    // Slave number carried in the top address nibble
    function automatic logic [SLV_HI-SLV_LO:0] slave_field(input logic [WB_AW-1:0] addr);
        return addr[SLV_HI:SLV_LO];
    endfunction

endpackage

// File: rtl/wb_shared_bus_if.sv
// rtl/wb_shared_bus_if.sv - master-side and slave-side signal bundle of the shared Wishbone bus
interface wb_shared_bus_if
    import wb_bus_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int NUM_S = 4
) ();

    logic [NUM_M-1:0]       m_cyc_i;
    logic [NUM_M-1:0]       m_stb_i;
    logic [NUM_M-1:0]       m_we_i;
    logic [NUM_M*WB_AW-1:0] m_addr_i;
    logic [NUM_M*WB_DW-1:0] m_data_i;
    logic [NUM_M*WB_SW-1:0] m_sel_i;
    logic [WB_DW-1:0]       m_data_o;
    logic [NUM_M-1:0]       m_ack_o;
    logic [NUM_M-1:0]       m_err_o;
    logic [NUM_S-1:0]       s_cyc_o;
    logic [NUM_S-1:0]       s_stb_o;
    logic [WB_AW-1:0]       s_addr_o;
    logic [WB_DW-1:0]       s_data_o;
    logic [WB_SW-1:0]       s_sel_o;
    logic                   s_we_o;
    logic [NUM_S*WB_DW-1:0] s_data_i;
    logic [NUM_S-1:0]       s_ack_i;
    logic [NUM_S-1:0]       s_err_i;
    logic [NUM_M-1:0]       gnt_o;

    modport bus (
        input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, m_sel_i,
        input  s_data_i, s_ack_i, s_err_i,
        output m_data_o, m_ack_o, m_err_o,
        output s_cyc_o, s_stb_o, s_addr_o, s_data_o, s_sel_o, s_we_o, gnt_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, m_sel_i,
        input  m_data_o, m_ack_o, m_err_o, gnt_o
    );

    modport slave (
        input  s_cyc_o, s_stb_o, s_addr_o, s_data_o, s_sel_o, s_we_o,
        output s_data_i, s_ack_i, s_err_i
    );

endinterface

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin winner search and last-owner pointer
module wb_rr_arbiter #(
    parameter int NUM_M = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_M-1:0]         req,
    input  logic                     take,
    output logic [$clog2(NUM_M)-1:0] win_idx,
    output logic                     win_valid
);

    localparam int IW = $clog2(NUM_M);

    logic [IW-1:0] last_q;

    // First requester found scanning upward from the master after the last owner
    always_comb begin
        win_idx   = '0;
        win_valid = 1'b0;
        for (int i = 1; i <= NUM_M; i++) begin
            if (!win_valid && req[IW'((int'(last_q) + i) % NUM_M)]) begin
                win_valid = 1'b1;
                win_idx   = IW'((int'(last_q) + i) % NUM_M);
            end
        end
    end

    // Pointer moves only when a grant is actually taken; starts at NUM_M-1 so master 0 wins first
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= IW'(NUM_M - 1);
        end else if (take && win_valid) begin
            last_q <= win_idx;
        end
    end

endmodule

// File: rtl/wb_shared_bus.sv
// rtl/wb_shared_bus.sv - shared Wishbone bus, round-robin masters to address-decoded slaves; WB_BUS_TIMEOUT_EN adds a stall timeout
module wb_shared_bus
    import wb_bus_pkg::*;
#(
    parameter int NUM_M       = 2,
    parameter int NUM_S       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    wb_shared_bus_if.bus  bus
);

    localparam int IW = $clog2(NUM_M);

    bus_state_t       state_q, state_d;
    logic [IW-1:0]    owner_q, win_idx;
    logic             win_valid, grant_take;
    logic [NUM_M-1:0] gnt_q;
    logic             err_pulse_q;

    logic             own_cyc, own_stb, own_we;
    logic [WB_AW-1:0] own_addr;
    logic [WB_DW-1:0] own_data;
    logic [WB_SW-1:0] own_sel;
    logic [3:0]       slv_idx;
    logic             slv_mapped, slv_ack, slv_err;
    logic [WB_DW-1:0] slv_rdata;
    logic             own_active, unmapped_stb, to_hit;

    assign grant_take = (state_q == ST_IDLE) && win_valid;

    wb_rr_arbiter #(.NUM_M(NUM_M)) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req       (bus.m_cyc_i),
        .take      (grant_take),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    // Pick out the current owner's request fields
    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_addr = '0;
        own_data = '0;
        own_sel  = '0;
        for (int m = 0; m < NUM_M; m++) begin
            if (owner_q == IW'(m)) begin
                own_cyc  = bus.m_cyc_i[m];
                own_stb  = bus.m_stb_i[m];
                own_we   = bus.m_we_i[m];
                own_addr = bus.m_addr_i[m*WB_AW +: WB_AW];
                own_data = bus.m_data_i[m*WB_DW +: WB_DW];
                own_sel  = bus.m_sel_i[m*WB_SW +: WB_SW];
            end
        end
    end

    // Decode the addressed slave and mux its response back
    always_comb begin
        slv_idx    = slave_field(own_addr);
        slv_mapped = (32'(slv_idx) < NUM_S);
        slv_ack    = 1'b0;
        slv_err    = 1'b0;
        slv_rdata  = '0;
        for (int k = 0; k < NUM_S; k++) begin
            if (slv_idx == 4'(k)) begin
                slv_ack   = bus.s_ack_i[k];
                slv_err   = bus.s_err_i[k];
                slv_rdata = bus.s_data_i[k*WB_DW +: WB_DW];
            end
        end
    end

    assign own_active   = (state_q == ST_OWNED) && own_cyc && own_stb;
    assign unmapped_stb = own_active && !slv_mapped;

`ifdef WB_BUS_TIMEOUT_EN
    logic [7:0] to_cnt_q;
    logic       stall;

    // Hit on the TIMEOUT_CYC-th consecutive unanswered strobe cycle; depends only on registered count
    assign to_hit = own_active && slv_mapped && (to_cnt_q == 8'(TIMEOUT_CYC - 1));
    assign stall  = own_active && slv_mapped && !slv_ack && !slv_err;

    // Count consecutive stalled strobe cycles, restarting on any response or on the timeout itself
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_q <= 8'd0;
        end else if (!stall || to_hit) begin
            to_cnt_q <= 8'd0;
        end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: take the bus on any request, release when the owner drops cyc
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|bus.m_cyc_i) state_d = ST_OWNED;
            ST_OWNED: if (!own_cyc)     state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Owner index, debug grant and the one-shot error for unmapped addresses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q     <= '0;
            gnt_q       <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            if (grant_take) begin
                owner_q <= win_idx;
                gnt_q   <= {{(NUM_M-1){1'b0}}, 1'b1} << win_idx;
            end else if ((state_q == ST_OWNED) && !own_cyc) begin
                gnt_q <= '0;
            end
            err_pulse_q <= unmapped_stb && !err_pulse_q;
        end
    end

    // FSM outputs: owner drives the shared buses, decoded slave answers the owner only
    always_comb begin
        bus.s_cyc_o  = '0;
        bus.s_stb_o  = '0;
        bus.s_addr_o = '0;
        bus.s_data_o = '0;
        bus.s_sel_o  = '0;
        bus.s_we_o   = 1'b0;
        bus.m_data_o = '0;
        bus.m_ack_o  = '0;
        bus.m_err_o  = '0;
        bus.gnt_o    = gnt_q;
        if (state_q == ST_OWNED) begin
            bus.s_addr_o = own_addr;
            bus.s_data_o = own_data;
            bus.s_sel_o  = own_sel;
            bus.s_we_o   = own_we;
            bus.m_data_o = slv_rdata;
            for (int k = 0; k < NUM_S; k++) begin
                if (own_cyc && slv_mapped && (slv_idx == 4'(k))) begin
                    bus.s_cyc_o[k] = 1'b1;
                    bus.s_stb_o[k] = own_stb && !to_hit;
                end
            end
            for (int m = 0; m < NUM_M; m++) begin
                if (owner_q == IW'(m)) begin
                    bus.m_ack_o[m] = own_active && slv_mapped && slv_ack && !to_hit;
                    bus.m_err_o[m] = (own_active && slv_mapped && slv_err) || err_pulse_q || to_hit;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_shared_bus.sv
// tb/tb_wb_shared_bus.sv - randomized self-checking bench for wb_shared_bus against a transaction-level model
module tb_wb_shared_bus;

    localparam int NM = 2;
    localparam int NS = 4;
    localparam int TO = 16;
    localparam logic [NM-1:0] ONE_M = 1;
    localparam logic [NS-1:0] ONE_S = 1;

    typedef struct {
        bit            ack;
        bit            err;
        logic [31:0]   data;
        logic [NS-1:0] stb_seen;
        logic [NS-1:0] stb_resp;
        logic [NM-1:0] gnt_seen;
        int            lat;
        logic [31:0]   saddr;
        logic [31:0]   sdata;
    } xres_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_shared_bus_if #(.NUM_M(NM), .NUM_S(NS)) bus ();

    wb_shared_bus #(.NUM_M(NM), .NUM_S(NS), .TIMEOUT_CYC(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int ref_last;
    logic [31:0] ref_mem [NS][16];
    logic [31:0] slv_mem [NS][16];

    // Round-robin rule: first requester after the previous owner, wrapping around
    function automatic int rr_pick(input int last, input logic [NM-1:0] req);
        logic [NM-1:0] r;
        for (int i = 1; i <= NM; i++) begin
            r = req >> ((last + i) % NM);
            if (r[0]) return (last + i) % NM;
        end
        return -1;
    endfunction

    task automatic set_master(input int m, input bit cyc, input bit stb, input bit we,
                              input logic [31:0] addr, input logic [31:0] data);
        logic [NM-1:0] b;
        b = ONE_M << m;
        bus.m_cyc_i = cyc ? (bus.m_cyc_i | b) : (bus.m_cyc_i & ~b);
        bus.m_stb_i = stb ? (bus.m_stb_i | b) : (bus.m_stb_i & ~b);
        bus.m_we_i  = we  ? (bus.m_we_i  | b) : (bus.m_we_i  & ~b);
        bus.m_addr_i[m*32 +: 32] = addr;
        bus.m_data_i[m*32 +: 32] = data;
        bus.m_sel_i[m*4 +: 4]    = 4'hF;
    endtask

    task automatic clear_all();
        bus.m_cyc_i  = '0;
        bus.m_stb_i  = '0;
        bus.m_we_i   = '0;
        bus.m_addr_i = '0;
        bus.m_data_i = '0;
        bus.m_sel_i  = '0;
        bus.s_data_i = '0;
        bus.s_ack_i  = '0;
        bus.s_err_i  = '0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        clear_all();
        @(posedge clk); #1;
        rst = 1'b0;
        ref_last = NM - 1;
    endtask

    // Drives one strobe from master m and plays the addressed slave (ack after lat stalled cycles)
    task automatic run_xfer(input int m, input bit we, input logic [31:0] addr, input logic [31:0] wdat,
                            input int lat, input bit hold, output xres_t r);
        int tgt;
        int stb_cnt;
        int gnt_at;
        bit done;
        logic [NS-1:0] sv;
        logic [NM-1:0] gv;
        tgt = int'(addr[31:28]);
        stb_cnt = 0;
        gnt_at = -1;
        done = 1'b0;
        r.ack = 0; r.err = 0; r.data = '0; r.stb_seen = '0; r.stb_resp = '0;
        r.gnt_seen = '0; r.lat = -1; r.saddr = '0; r.sdata = '0;
        set_master(m, 1'b1, 1'b1, we, addr, wdat);
        for (int n = 0; n < 40; n++) begin
            #1;
            bus.s_ack_i = '0;
            sv = bus.s_stb_o >> tgt;
            if (tgt < NS && sv[0]) begin
                if (stb_cnt == lat) begin
                    bus.s_ack_i = ONE_S << tgt;
                    bus.s_data_i[tgt*32 +: 32] = slv_mem[tgt][addr[5:2]];
                    if (bus.s_we_o) slv_mem[tgt][addr[5:2]] = bus.s_data_o;
                end
                stb_cnt++;
            end
            @(negedge clk);
            r.stb_seen |= bus.s_stb_o;
            r.gnt_seen |= bus.gnt_o;
            gv = bus.gnt_o >> m;
            if (gnt_at < 0 && gv[0]) gnt_at = n;
            if (bus.m_ack_o != '0 || bus.m_err_o != '0) begin
                gv = bus.m_ack_o >> m;
                r.ack = gv[0];
                gv = bus.m_err_o >> m;
                r.err = gv[0];
                r.data = bus.m_data_o;
                r.stb_resp = bus.s_stb_o;
                r.saddr = bus.s_addr_o;
                r.sdata = bus.s_data_o;
                r.lat = n - gnt_at;
                done = 1'b1;
            end
            @(posedge clk); #1;
            if (done) break;
        end
        bus.s_ack_i = '0;
        set_master(m, hold, 1'b0, 1'b0, 32'h0, 32'h0);
        if (!hold) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_all();
        set_master(0, 1'b1, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (bus.gnt_o !== '0)   begin bad++; $display("FAIL reset_gnt got=%b want=0", bus.gnt_o); end
        total++; if (bus.s_stb_o !== '0) begin bad++; $display("FAIL reset_stb got=%b want=0", bus.s_stb_o); end
        total++; if (bus.s_cyc_o !== '0) begin bad++; $display("FAIL reset_cyc got=%b want=0", bus.s_cyc_o); end
        total++; if (bus.m_ack_o !== '0 || bus.m_err_o !== '0) begin bad++; $display("FAIL reset_ackerr got=%b/%b want=0/0", bus.m_ack_o, bus.m_err_o); end
        total++; if (bus.s_addr_o !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", bus.s_addr_o); end
        @(posedge clk); #1;
        clear_all();
        rst = 1'b0;
        ref_last = NM - 1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_basic();
        xres_t r;
        int exp_m;
        slv_mem[1][1] = 32'hDEAD_BEEF;
        ref_mem[1][1] = 32'hDEAD_BEEF;
        exp_m = rr_pick(ref_last, ONE_M << 0);
        run_xfer(0, 1'b0, 32'h1000_0004, 32'h0, 2, 1'b0, r);
        ref_last = exp_m;
        total++; if (r.ack !== 1'b1 || r.err !== 1'b0) begin bad++; $display("FAIL read_ack got=%0d/%0d want=1/0", r.ack, r.err); end
        total++; if (r.data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_data got=%h want=deadbeef", r.data); end
        total++; if (r.stb_seen !== 4'b0010) begin bad++; $display("FAIL read_stb got=%b want=0010", r.stb_seen); end
        total++; if (r.gnt_seen !== (ONE_M << exp_m)) begin bad++; $display("FAIL read_gnt got=%b want=%b", r.gnt_seen, ONE_M << exp_m); end
        total++; if (r.lat !== 2) begin bad++; $display("FAIL read_latency got=%0d want=2", r.lat); end
    endtask

    task automatic test_rr_same_cycle();
        int exp_m;
        pulse_reset();
        for (int round = 0; round < 3; round++) begin
            set_master(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            set_master(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            exp_m = rr_pick(ref_last, 2'b11);
            @(negedge clk);
            total++; if (bus.gnt_o !== '0) begin bad++; $display("FAIL rr_idle_gnt round=%0d got=%b want=0", round, bus.gnt_o); end
            @(posedge clk); #1;
            @(negedge clk);
            total++; if (bus.gnt_o !== (ONE_M << exp_m)) begin bad++; $display("FAIL rr_grant round=%0d got=%b want=%b", round, bus.gnt_o, ONE_M << exp_m); end
            ref_last = exp_m;
            @(posedge clk); #1;
            clear_all();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_unmapped();
        xres_t r;
        int exp_m;
        exp_m = rr_pick(ref_last, ONE_M << 1);
        run_xfer(1, 1'b1, 32'h7000_0000, 32'h1234_5678, 0, 1'b1, r);
        ref_last = exp_m;
        total++; if (r.err !== 1'b1 || r.ack !== 1'b0) begin bad++; $display("FAIL unmapped_err got=%0d/%0d want=err1/ack0", r.err, r.ack); end
        total++; if (r.stb_seen !== '0) begin bad++; $display("FAIL unmapped_stb got=%b want=0", r.stb_seen); end
        total++; if (r.lat !== 1) begin bad++; $display("FAIL unmapped_latency got=%0d want=1", r.lat); end
        total++; if (r.gnt_seen !== (ONE_M << exp_m)) begin bad++; $display("FAIL unmapped_gnt got=%b want=%b", r.gnt_seen, ONE_M << exp_m); end
        @(negedge clk);
        total++; if (bus.m_err_o !== '0) begin bad++; $display("FAIL unmapped_pulse_width got=%b want=0", bus.m_err_o); end
        @(posedge clk); #1;
        clear_all();
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        xres_t r;
        int own;
        int oth;
        int s;
        int w;
        int lat;
        logic [31:0] d;
        logic [31:0] a;
        bit found;
        bit stray;
        own = rr_pick(ref_last, 2'b11);
        oth = (own + 1) % NM;
        set_master(oth, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            s = $urandom_range(0, NS - 1);
            w = $urandom_range(0, 15);
            lat = $urandom_range(0, 2);
            d = $urandom;
            a = {4'(s), 22'h0, 4'(w), 2'b00};
            run_xfer(own, 1'b1, a, d, lat, 1'b1, r);
            ref_mem[s][w] = d;
            total++; if (r.ack !== 1'b1) begin bad++; $display("FAIL b2b_ack k=%0d got=%0d want=1", k, r.ack); end
            total++; if (r.gnt_seen !== (ONE_M << own)) begin bad++; $display("FAIL b2b_gnt k=%0d got=%b want=%b", k, r.gnt_seen, ONE_M << own); end
            total++; if (r.sdata !== d || r.saddr !== a) begin bad++; $display("FAIL b2b_wdata k=%0d got=%h@%h want=%h@%h", k, r.sdata, r.saddr, d, a); end
        end
        ref_last = own;
        set_master(own, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        total++; if (bus.s_cyc_o !== '0) begin bad++; $display("FAIL b2b_drop_cyc got=%b want=0", bus.s_cyc_o); end
        total++; if (bus.gnt_o !== (ONE_M << own)) begin bad++; $display("FAIL b2b_hold_gnt got=%b want=%b", bus.gnt_o, ONE_M << own); end
        found = 1'b0;
        stray = 1'b0;
        for (int n = 0; n < 4 && !found; n++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.gnt_o === (ONE_M << oth)) found = 1'b1;
            else if (bus.gnt_o !== '0) stray = 1'b1;
        end
        total++; if (!found || stray) begin bad++; $display("FAIL b2b_handover got=found%0d/stray%0d want=found1/stray0", found, stray); end
        ref_last = oth;
        @(posedge clk); #1;
        clear_all();
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        xres_t r;
        int m;
        int s;
        int w;
        int lat;
        bit we;
        logic [31:0] d;
        logic [31:0] a;
        int exp_m;
        for (int it = 0; it < 24; it++) begin
            m = $urandom_range(0, NM - 1);
            s = $urandom_range(0, NS - 1);
            w = $urandom_range(0, 15);
            lat = $urandom_range(0, 3);
            we = 1'($urandom_range(0, 1));
            d = $urandom;
            a = {4'(s), 22'h0, 4'(w), 2'b00};
            exp_m = rr_pick(ref_last, ONE_M << m);
            run_xfer(m, we, a, d, lat, 1'b0, r);
            ref_last = exp_m;
            total++; if (r.ack !== 1'b1 || r.err !== 1'b0) begin bad++; $display("FAIL rnd_ack it=%0d got=%0d/%0d want=1/0", it, r.ack, r.err); end
            total++; if (r.stb_seen !== (ONE_S << s)) begin bad++; $display("FAIL rnd_stb it=%0d got=%b want=%b", it, r.stb_seen, ONE_S << s); end
            total++; if (r.gnt_seen !== (ONE_M << exp_m)) begin bad++; $display("FAIL rnd_gnt it=%0d got=%b want=%b", it, r.gnt_seen, ONE_M << exp_m); end
            total++; if (r.lat !== lat) begin bad++; $display("FAIL rnd_latency it=%0d got=%0d want=%0d", it, r.lat, lat); end
            if (we) begin
                total++; if (r.sdata !== d || r.saddr !== a) begin bad++; $display("FAIL rnd_write it=%0d got=%h@%h want=%h@%h", it, r.sdata, r.saddr, d, a); end
                ref_mem[s][w] = d;
            end else begin
                total++; if (r.data !== ref_mem[s][w]) begin bad++; $display("FAIL rnd_read it=%0d got=%h want=%h", it, r.data, ref_mem[s][w]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        logic [NS-1:0] sv;
        int exp_m;
        seen = 1'b0;
        set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            sv = bus.s_stb_o;
            if (sv[0]) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        total++; if (!seen) begin bad++; $display("FAIL rstmid_stb_before got=0 want=1"); end
        #1;
        bus.s_ack_i = ONE_S;
        bus.s_data_i[31:0] = 32'hA5A5_A5A5;
        rst = 1'b1;
        set_master(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        total++; if (bus.s_stb_o !== '0 || bus.s_cyc_o !== '0) begin bad++; $display("FAIL rstmid_stb got=%b/%b want=0/0", bus.s_stb_o, bus.s_cyc_o); end
        total++; if (bus.gnt_o !== '0) begin bad++; $display("FAIL rstmid_gnt got=%b want=0", bus.gnt_o); end
        total++; if (bus.m_ack_o !== '0) begin bad++; $display("FAIL rstmid_ack got=%b want=0", bus.m_ack_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.s_ack_i = '0;
        ref_last = NM - 1;
        exp_m = rr_pick(ref_last, 2'b11);
        @(negedge clk);
        total++; if (bus.gnt_o !== '0) begin bad++; $display("FAIL rstmid_idle got=%b want=0", bus.gnt_o); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (bus.gnt_o !== (ONE_M << exp_m)) begin bad++; $display("FAIL rstmid_first_gnt got=%b want=%b", bus.gnt_o, ONE_M << exp_m); end
        ref_last = exp_m;
        @(posedge clk); #1;
        clear_all();
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

`ifdef WB_BUS_TIMEOUT_EN
    task automatic test_timeout();
        xres_t r;
        int exp_m;
        bit found;
        exp_m = rr_pick(ref_last, ONE_M << 0);
        run_xfer(0, 1'b0, 32'h2000_0000, 32'h0, 1000, 1'b1, r);
        ref_last = exp_m;
        total++; if (r.err !== 1'b1 || r.ack !== 1'b0) begin bad++; $display("FAIL timeout_err got=%0d/%0d want=err1/ack0", r.err, r.ack); end
        total++; if (r.lat !== TO - 1) begin bad++; $display("FAIL timeout_cycle got=%0d want=%0d", r.lat + 1, TO); end
        total++; if (r.stb_resp !== '0) begin bad++; $display("FAIL timeout_mask got=%b want=0", r.stb_resp); end
        total++; if (r.stb_seen !== 4'b0100) begin bad++; $display("FAIL timeout_stb got=%b want=0100", r.stb_seen); end
        set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_master(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        exp_m = rr_pick(ref_last, ONE_M << 1);
        found = 1'b0;
        for (int n = 0; n < 4 && !found; n++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.gnt_o === (ONE_M << exp_m)) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL timeout_rearb got=%b want=%b", bus.gnt_o, ONE_M << exp_m); end
        ref_last = exp_m;
        @(posedge clk); #1;
        clear_all();
        @(posedge clk); #1;
    endtask
`else
    task automatic test_no_timeout();
        xres_t r;
        run_xfer(0, 1'b0, 32'h2000_0000, 32'h0, 1000, 1'b0, r);
        ref_last = 0;
        total++; if (r.err !== 1'b0 || r.ack !== 1'b0) begin bad++; $display("FAIL stall_no_err got=%0d/%0d want=0/0", r.err, r.ack); end
        total++; if (r.stb_seen !== 4'b0100) begin bad++; $display("FAIL stall_stb got=%b want=0100", r.stb_seen); end
        clear_all();
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ref_last = NM - 1;
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < 16; w++) begin
                ref_mem[s][w] = $urandom;
                slv_mem[s][w] = ref_mem[s][w];
            end
        end
        test_reset();
        test_read_basic();
        test_rr_same_cycle();
        test_unmapped();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef WB_BUS_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
